// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared frame layout, state and command types for the SPI command link
package spi_cmd_pkg;

  localparam int FRAME_BITS = 18;
  localparam int WAVE_W     = 2;
  localparam int DIV_W      = 16;

  typedef enum logic [1:0] {ARM, IDLE, SHIFT, CHECK} rx_state_t;

  typedef struct packed {
    logic [DIV_W-1:0]  div;
    logic [WAVE_W-1:0] wave;
  } spi_cmd_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d,
                                                 input logic [DIV_W-1:0] lo);
    return (d < lo) ? lo : d;
  endfunction

endpackage

// File: rtl/spi_cmd_receiver_if.sv
// rtl/spi_cmd_receiver_if.sv - SPI pins plus latched command outputs of the receiver
interface spi_cmd_receiver_if;
  import spi_cmd_pkg::*;

  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic [WAVE_W-1:0] waveform_sel;
  logic [DIV_W-1:0]  divider;
  logic              cmd_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output sclk, mosi, cs_n,
    input  waveform_sel, divider, cmd_valid, frame_err, busy
  );

  modport slave (
    input  sclk, mosi, cs_n,
    output waveform_sel, divider, cmd_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_cmd_receiver_sync_edge.sv
// rtl/spi_cmd_receiver_sync_edge.sv - multi-flop synchronizer with registered rise/fall pulses
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // level is the delayed copy so it lines up with the rise/fall pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign level = last_q;

endmodule

// File: rtl/spi_cmd_receiver.sv
// rtl/spi_cmd_receiver.sv - oversampled SPI slave latching 18-bit {divider, waveform_sel} commands
// Optional divider lower clamp enabled by defining SPIRX_DIV_MIN_EN.
module spi_cmd_receiver
  import spi_cmd_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [DIV_W-1:0] DIV_RESET   = 16'd5,
  parameter logic [DIV_W-1:0] DIV_MIN     = 16'd1
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_cmd_receiver_if.slave   bus
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(bus.sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(bus.cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sclk;
  assign unused_sclk = sclk_level ^ sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
  end

  rx_state_t              state;
  logic [FRAME_BITS-1:0]  shreg;
  logic [4:0]             bit_cnt;
  logic [WAVE_W-1:0]      wave_q;
  logic [DIV_W-1:0]       div_q;
  logic                   cmd_valid_q, frame_err_q, busy_q;
  spi_cmd_t               rx_cmd;

  assign rx_cmd = spi_cmd_t'(shreg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      shreg       <= '0;
      bit_cnt     <= '0;
      wave_q      <= '0;
      div_q       <= DIV_RESET;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        // a frame already running when reset lifted must end before we listen
        ARM: if (cs_level) state <= IDLE;
        IDLE: begin
          if (cs_fall || !cs_level) begin
            state   <= SHIFT;
            busy_q  <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // chip-select release takes priority over a coincident sclk rise
          if (cs_rise || cs_level) begin
            state  <= CHECK;
            busy_q <= 1'b0;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_q[SYNC_STAGES-1]};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (bit_cnt == 5'(FRAME_BITS)) begin
            wave_q      <= rx_cmd.wave;
`ifdef SPIRX_DIV_MIN_EN
            div_q       <= clamp_div(rx_cmd.div, DIV_MIN);
`else
            div_q       <= rx_cmd.div;
`endif
            cmd_valid_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

`ifndef SPIRX_DIV_MIN_EN
  logic [DIV_W-1:0] unused_div_min;
  assign unused_div_min = DIV_MIN;
`endif

  assign bus.waveform_sel = wave_q;
  assign bus.divider      = div_q;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb/tb_spi_cmd_receiver.sv - random and directed frames checked against a frame-level model
module tb_spi_cmd_receiver;
  import spi_cmd_pkg::*;

  localparam int          SYNC      = 2;
  localparam logic [15:0] DIV_RESET = 16'd5;
  localparam logic [15:0] DIV_MIN   = 16'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_receiver_if ifc();

  spi_cmd_receiver #(
    .SYNC_STAGES(SYNC), .DIV_RESET(DIV_RESET), .DIV_MIN(DIV_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  typedef struct {
    int          cyc;
    bit          ok;
    logic [15:0] div;
    logic [1:0]  wave;
  } ev_t;

  ev_t         evq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          n_err = 0;
  logic [15:0] exp_div = DIV_RESET;
  logic [1:0]  exp_wave = 2'd0;
  bit          armed = 1'b0;
  int          nbits = 0;
  logic [63:0] frame_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] accepted_div(input logic [15:0] d);
`ifdef SPIRX_DIV_MIN_EN
    return (d < DIV_MIN) ? DIV_MIN : d;
`else
    return d;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each armed frame ends in exactly one pulse, SYNC+2 edges after cs_n is first seen high
  always @(negedge clk) begin
    bit want_v, want_e;
    ev_t ev;
    want_v = 1'b0;
    want_e = 1'b0;
    if (!rst_n) begin
      evq.delete();
      exp_div  = DIV_RESET;
      exp_wave = 2'd0;
    end else begin
      if (evq.size() > 0 && evq[0].cyc < cyc) begin
        check("pulse_overdue", 32'(evq[0].cyc), 32'(cyc));
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        if (ev.ok) begin
          want_v   = 1'b1;
          exp_div  = ev.div;
          exp_wave = ev.wave;
        end else begin
          want_e = 1'b1;
        end
      end
    end
    check("cmd_valid", 32'(ifc.cmd_valid), 32'(want_v));
    check("frame_err", 32'(ifc.frame_err), 32'(want_e));
    check("divider", 32'(ifc.divider), 32'(exp_div));
    check("waveform_sel", 32'(ifc.waveform_sel), 32'(exp_wave));
    if (ifc.cmd_valid === 1'b1) n_valid++;
    if (ifc.frame_err === 1'b1) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    ifc.cs_n   = 1'b0;
    armed      = (rst_n === 1'b1);
    nbits      = 0;
    frame_word = '0;
  endtask

  task automatic shift_bits(input logic [31:0] data, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      ifc.mosi = data[i];
      tick(half);
      ifc.sclk = 1'b1;
      tick(half);
      ifc.sclk = 1'b0;
      nbits++;
      frame_word = {frame_word[62:0], data[i]};
    end
  endtask

  task automatic frame_end(input int half);
    ev_t ev;
    tick(half);
    ifc.cs_n = 1'b1;
    if (armed) begin
      ev.cyc  = cyc + SYNC + 3;
      ev.ok   = (nbits == FRAME_BITS);
      ev.div  = accepted_div(frame_word[17:2]);
      ev.wave = frame_word[1:0];
      evq.push_back(ev);
    end
    armed = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input int n, input int half);
    frame_begin();
    tick(half);
    shift_bits(data, n, half);
    frame_end(half);
  endtask

  task automatic settle();
    int t;
    t = 0;
    while (evq.size() > 0 && t < 400) begin
      tick(1);
      t++;
    end
    check("settle_queue_empty", 32'(evq.size()), 32'd0);
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, n, half, gap;
    int lens[8];
    lens = '{18, 18, 18, 17, 19, 16, 20, 1};
    ifc.sclk = 1'b0;
    ifc.mosi = 1'b0;
    ifc.cs_n = 1'b1;
    tick(3);
    check("reset_divider", 32'(ifc.divider), 32'd5);
    check("reset_wave", 32'(ifc.waveform_sel), 32'd0);
    check("reset_busy", 32'(ifc.busy), 32'd0);
    rst_n = 1'b1;
    tick(6);

    v0 = n_valid; e0 = n_err;
    send(32'({16'd5, 2'b01}), 18, 5);
    settle();
    check("t1_valid_count", 32'(n_valid - v0), 32'd1);
    check("t1_err_count", 32'(n_err - e0), 32'd0);
    check("t1_divider", 32'(ifc.divider), 32'd5);
    check("t1_wave", 32'(ifc.waveform_sel), 32'd1);

    v0 = n_valid; e0 = n_err;
    send(32'h1_ABCD, 17, 5);
    settle();
    check("t2_err_count", 32'(n_err - e0), 32'd1);
    check("t2_valid_count", 32'(n_valid - v0), 32'd0);
    check("t2_divider", 32'(ifc.divider), 32'd5);
    check("t2_wave", 32'(ifc.waveform_sel), 32'd1);

    e0 = n_err;
    send(32'({1'b1, 16'hABCD, 2'b10}), 19, 5);
    settle();
    check("t3_err_count", 32'(n_err - e0), 32'd1);
    check("t3_divider", 32'(ifc.divider), 32'd5);
    check("t3_busy", 32'(ifc.busy), 32'd0);

    v0 = n_valid; e0 = n_err;
    frame_begin();
    tick(5);
    shift_bits(32'h3_5A5A, 9, 5);
    check("t4_busy_mid", 32'(ifc.busy), 32'd1);
    rst_n = 1'b0;
    armed = 1'b0;
    tick(3);
    check("t4_reset_divider", 32'(ifc.divider), 32'd5);
    check("t4_reset_wave", 32'(ifc.waveform_sel), 32'd0);
    rst_n = 1'b1;
    shift_bits(32'h1A5, 9, 5);
    frame_end(5);
    settle();
    check("t4_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    check("t4_divider", 32'(ifc.divider), 32'd5);
    send(32'({16'd300, 2'b11}), 18, 5);
    settle();
    check("t4_next_divider", 32'(ifc.divider), 32'd300);
    check("t4_next_wave", 32'(ifc.waveform_sel), 32'd3);

    v0 = n_valid;
    send(32'({16'd7, 2'b00}), 18, 5);
    tick(2);
    send(32'({16'd9, 2'b10}), 18, 5);
    settle();
    check("t5_valid_count", 32'(n_valid - v0), 32'd2);
    check("t5_divider", 32'(ifc.divider), 32'd9);
    check("t5_wave", 32'(ifc.waveform_sel), 32'd2);

    send(32'({16'd0, 2'b01}), 18, 5);
    settle();
`ifdef SPIRX_DIV_MIN_EN
    check("t6_divider_clamped", 32'(ifc.divider), 32'd1);
`else
    check("t6_divider_zero", 32'(ifc.divider), 32'd0);
`endif
    check("t6_wave", 32'(ifc.waveform_sel), 32'd1);

    v0 = n_valid;
    send(32'({16'd9, 2'b01}), 18, 4);
    tick(3);
    send(32'({16'd9, 2'b01}), 18, 6);
    settle();
    check("repeat_valid_count", 32'(n_valid - v0), 32'd2);

    for (int k = 0; k < 40; k++) begin
      n    = lens[$urandom_range(0, 7)];
      half = $urandom_range(4, 6);
      gap  = $urandom_range(2, 15);
      send($urandom, n, half);
      tick(gap);
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
